fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding and default fetch constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_t;

    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register,
// with stall freeze, redirect priority and discard of in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRValid,
    input  logic [31:0] imemRData,
    output logic [31:0] opcode,
    output logic [31:0] pcID,
    output logic        MuxControlEn
);

    fetch_state_t state, next_state;
    logic         discard, next_discard;
    logic [31:0]  pc;
    logic [31:0]  hold_word;
    logic         deliver;
    logic [31:0]  deliver_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH_IDLE;
            discard <= 1'b0;
        end else begin
            state   <= next_state;
            discard <= next_discard;
        end
    end

    always_comb begin
        next_state   = state;
        next_discard = discard;
        deliver      = 1'b0;
        deliver_word = imemRData;
        case (state)
            FETCH_IDLE: next_state = FETCH_REQ;
            FETCH_REQ: begin
                if (imemReady) begin
                    next_state   = FETCH_WAIT;
                    // Redirect in the accepting cycle leaves a stale response in flight.
                    next_discard = PCSrc;
                end
            end
            FETCH_WAIT: begin
                if (imemRValid) begin
                    next_discard = 1'b0;
                    if (discard || PCSrc) begin
                        next_state = FETCH_REQ;
                    end else if (Stall) begin
                        next_state = FETCH_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        next_state = FETCH_REQ;
                    end
                end else if (PCSrc) begin
                    next_discard = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (PCSrc) begin
                    next_state = FETCH_REQ;
                end else if (!Stall) begin
                    deliver      = 1'b1;
                    deliver_word = hold_word;
                    next_state   = FETCH_REQ;
                end
            end
            default: next_state = FETCH_IDLE;
        endcase
    end

    always_comb begin
        imemReq  = (state == FETCH_REQ);
        imemAddr = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            opcode       <= NOP_INSTR;
            pcID         <= 32'h0;
            MuxControlEn <= 1'b1;
        end else begin
            if (PCSrc) begin
                pc <= {PCTarget[31:2], 2'b00};
            end else if (deliver) begin
                pc <= pc + 32'd4;
            end
            // deliver is never set with PCSrc or Stall high, so it only competes with the bubble.
            if (deliver) begin
                opcode       <= deliver_word;
                pcID         <= pc;
                MuxControlEn <= 1'b0;
            end else if (PCSrc || !Stall) begin
                opcode       <= NOP_INSTR;
                MuxControlEn <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH_WAIT && imemRValid) begin
            hold_word <= imemRData;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory and checks IF/ID
// deliveries against a scoreboard of expected {pc, word} pairs.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRValid;
    logic [31:0] imemRData;
    logic [31:0] opcode;
    logic [31:0] pcID;
    logic        MuxControlEn;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemRValid(imemRValid), .imemRData(imemRData),
        .opcode(opcode), .pcID(pcID), .MuxControlEn(MuxControlEn)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_for(input logic [31:0] addr);
        return 32'h0050_0093 + (addr << 10);
    endfunction

    task automatic pop_delivery(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_opcode"}, opcode, e[31:0]);
            check_eq({tag, "_pcID"}, pcID, e[63:32]);
            check_eq({tag, "_mux"}, {31'd0, MuxControlEn}, 32'd0);
        end
    endtask

    // Expects the DUT in REQ at exp_pc; serves it with a 1-cycle memory and checks delivery.
    task automatic do_fetch(input string tag);
        logic [31:0] w;
        w = instr_for(exp_pc);
        check_eq({tag, "_req"}, {31'd0, imemReq}, 32'd1);
        check_eq({tag, "_addr"}, imemAddr, exp_pc);
        imemReady = 1'b1;
        tick();
        imemReady = 1'b0;
        check_eq({tag, "_wait_bubble"}, {31'd0, MuxControlEn}, 32'd1);
        exp_q.push_back({exp_pc, w});
        imemRValid = 1'b1;
        imemRData  = w;
        tick();
        imemRValid = 1'b0;
        pop_delivery(tag);
        exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        rst_n = 1'b0; Stall = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        imemReady = 1'b0; imemRValid = 1'b0; imemRData = 32'h0;
        tick();
        tick();
        check_eq("rst_req", {31'd0, imemReq}, 32'd0);
        check_eq("rst_addr", imemAddr, 32'h0);
        check_eq("rst_opcode", opcode, NOP);
        check_eq("rst_pcID", pcID, 32'h0);
        check_eq("rst_mux", {31'd0, MuxControlEn}, 32'd1);

        // Reset release and first fetches from 0
        rst_n = 1'b1;
        tick();
        exp_pc = 32'h0;
        check_eq("first_word", instr_for(32'h0), 32'h0050_0093);
        do_fetch("f0");
        check_eq("f0_next_addr", imemAddr, 32'h4);
        do_fetch("f4");

        // Stall across the response at PC=8: IF/ID frozen on the word from 4
        check_eq("st_addr", imemAddr, 32'h8);
        Stall = 1'b1; imemReady = 1'b1;
        tick();
        imemReady = 1'b0;
        imemRValid = 1'b1; imemRData = instr_for(32'h8);
        tick();
        imemRValid = 1'b0; imemRData = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            check_eq("st_frozen_opcode", opcode, instr_for(32'h4));
            check_eq("st_frozen_pcID", pcID, 32'h4);
            check_eq("st_frozen_mux", {31'd0, MuxControlEn}, 32'd0);
            check_eq("st_no_req", {31'd0, imemReq}, 32'd0);
            tick();
        end
        exp_q.push_back({32'h8, instr_for(32'h8)});
        Stall = 1'b0;
        tick();
        pop_delivery("st_release");
        exp_pc = 32'hC;
        while (exp_pc != 32'h20) do_fetch("walk");

        // Redirect during WAIT at 0x20 to 0x103
        check_eq("rw_addr", imemAddr, 32'h20);
        imemReady = 1'b1;
        tick();
        imemReady = 1'b0;
        PCSrc = 1'b1; PCTarget = 32'h103;
        tick();
        PCSrc = 1'b0;
        check_eq("rw_bubble_mux", {31'd0, MuxControlEn}, 32'd1);
        check_eq("rw_bubble_opcode", opcode, NOP);
        check_eq("rw_no_req", {31'd0, imemReq}, 32'd0);
        imemRValid = 1'b1; imemRData = instr_for(32'h20);
        tick();
        imemRValid = 1'b0;
        check_eq("rw_dropped_mux", {31'd0, MuxControlEn}, 32'd1);
        check_eq("rw_dropped_opcode", opcode, NOP);
        check_eq("rw_new_addr", imemAddr, 32'h100);
        exp_pc = 32'h100;
        do_fetch("rw_target");

        // Redirect in the same cycle the request at 0x104 is accepted
        imemReady = 1'b1; PCSrc = 1'b1; PCTarget = 32'h200;
        tick();
        imemReady = 1'b0; PCSrc = 1'b0;
        check_eq("ra_wait_no_req", {31'd0, imemReq}, 32'd0);
        imemRValid = 1'b1; imemRData = instr_for(32'h104);
        tick();
        imemRValid = 1'b0;
        check_eq("ra_dropped_mux", {31'd0, MuxControlEn}, 32'd1);
        check_eq("ra_new_addr", imemAddr, 32'h200);
        exp_pc = 32'h200;
        do_fetch("ra_target");

        // Redirect and stall together: redirect wins
        Stall = 1'b1; PCSrc = 1'b1; PCTarget = 32'h300;
        tick();
        Stall = 1'b0; PCSrc = 1'b0;
        check_eq("rs_mux", {31'd0, MuxControlEn}, 32'd1);
        check_eq("rs_opcode", opcode, NOP);
        check_eq("rs_pcID", pcID, 32'h200);
        check_eq("rs_addr", imemAddr, 32'h300);
        exp_pc = 32'h300;
        do_fetch("rs_target");

        // Redirect to the top word (low bits forced clear), backpressure, then wrap
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF;
        tick();
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_req", {31'd0, imemReq}, 32'd1);
            check_eq("bp_addr", imemAddr, 32'hFFFF_FFFC);
            tick();
        end
        exp_pc = 32'hFFFF_FFFC;
        do_fetch("wrap");
        check_eq("wrap_addr", imemAddr, 32'h0);

        // Asynchronous reset in WAIT, then a late response must be ignored
        imemReady = 1'b1;
        tick();
        imemReady = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mr_req", {31'd0, imemReq}, 32'd0);
        check_eq("mr_addr", imemAddr, 32'h0);
        check_eq("mr_opcode", opcode, NOP);
        check_eq("mr_pcID", pcID, 32'h0);
        check_eq("mr_mux", {31'd0, MuxControlEn}, 32'd1);
        tick();
        rst_n = 1'b1;
        imemRValid = 1'b1; imemRData = 32'hDEAD_BEEF;
        tick();
        check_eq("late_mux", {31'd0, MuxControlEn}, 32'd1);
        check_eq("late_req", {31'd0, imemReq}, 32'd1);
        tick();
        imemRValid = 1'b0;
        check_eq("late_opcode", opcode, NOP);
        check_eq("late_pcID", pcID, 32'h0);
        exp_pc = 32'h0;
        do_fetch("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
